// File: rtl/stopwatch_mux.sv
// Stopwatch counting hh:mm:ss.cc in BCD, driving an 8-digit multiplexed 7-segment display.
// Define LAP_EN to build the lap (frozen display snapshot) feature; without it lap is ignored.

module stopwatch_mux #(
   parameter int CYC_PER_CS = 10,
   parameter int SCAN_DIV   = 1,
   parameter int HOUR_WRAP  = 24
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start_stop,
   input  logic        clear,
   input  logic        lap,
   output logic [7:0]  seg_data,
   output logic [7:0]  seg_com,
   output logic        running,
   output logic [31:0] time_bcd
);

`ifdef LAP_EN
   typedef enum logic [1:0] {IDLE, RUN, PAUSE, LAP} state_t;
`else
   typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;
`endif

   localparam logic [15:0] PRE_LAST   = 16'(CYC_PER_CS - 1);
   localparam logic [7:0]  SCAN_LAST  = 8'(SCAN_DIV - 1);
   localparam logic [3:0]  H_TEN_LAST = 4'((HOUR_WRAP - 1) / 10);
   localparam logic [3:0]  H_ONE_LAST = 4'((HOUR_WRAP - 1) % 10);

   state_t      r_state;
   logic [31:0] r_time;
   logic [15:0] r_pre;
   logic        r_running;
   logic [2:0]  r_slot;
   logic [7:0]  r_scanDiv;
   logic [7:0]  r_segData;
   logic [7:0]  r_segCom;
`ifdef LAP_EN
   logic [31:0] r_snap;
   logic        r_frozen;
`else
   logic        w_unusedLap;
`endif

   logic        w_counting;
   logic        w_tick;
   logic [31:0] w_dispTime;
   logic [3:0]  w_digit;
   logic        w_dp;

   function automatic logic [4:0] stepDigit(input logic [3:0] d, input logic [3:0] last,
                                            input logic cin);
      if (!cin)
         return {1'b0, d};
      else if (d >= last)
         return {1'b1, 4'd0};
      else
         return {1'b0, d + 4'd1};
   endfunction

   // One centisecond step; hours wrap on the (tens, ones) pair so 24 and 100 share one path.
   function automatic logic [31:0] incTime(input logic [31:0] t);
      logic [31:0] n;
      logic [4:0]  st;
      n  = t;
      st = stepDigit(t[3:0],   4'd9, 1'b1);  n[3:0]   = st[3:0];
      st = stepDigit(t[7:4],   4'd9, st[4]); n[7:4]   = st[3:0];
      st = stepDigit(t[11:8],  4'd9, st[4]); n[11:8]  = st[3:0];
      st = stepDigit(t[15:12], 4'd5, st[4]); n[15:12] = st[3:0];
      st = stepDigit(t[19:16], 4'd9, st[4]); n[19:16] = st[3:0];
      st = stepDigit(t[23:20], 4'd5, st[4]); n[23:20] = st[3:0];
      if (st[4]) begin
         if (t[31:28] == H_TEN_LAST && t[27:24] == H_ONE_LAST) begin
            n[31:24] = 8'h00;
         end else begin
            st = stepDigit(t[27:24], 4'd9, 1'b1);  n[27:24] = st[3:0];
            st = stepDigit(t[31:28], 4'd9, st[4]); n[31:28] = st[3:0];
         end
      end
      return n;
   endfunction

   function automatic logic [7:0] segOf(input logic [3:0] d);
      case (d)
         4'd0:    return 8'hFC;
         4'd1:    return 8'h60;
         4'd2:    return 8'hDA;
         4'd3:    return 8'hF2;
         4'd4:    return 8'h66;
         4'd5:    return 8'hB6;
         4'd6:    return 8'hBE;
         4'd7:    return 8'hE0;
         4'd8:    return 8'hFE;
         4'd9:    return 8'hF6;
         default: return 8'h00;
      endcase
   endfunction

   always_comb begin
`ifdef LAP_EN
      w_counting = (r_state == RUN) || (r_state == LAP);
      w_dispTime = r_frozen ? r_snap : r_time;
`else
      w_counting = (r_state == RUN);
      w_dispTime = r_time;
`endif
      w_tick = w_counting && (r_pre == PRE_LAST);
      w_dp   = r_slot[0] && (r_slot != 3'd7);
      case (r_slot)
         3'd0:    w_digit = w_dispTime[31:28];
         3'd1:    w_digit = w_dispTime[27:24];
         3'd2:    w_digit = w_dispTime[23:20];
         3'd3:    w_digit = w_dispTime[19:16];
         3'd4:    w_digit = w_dispTime[15:12];
         3'd5:    w_digit = w_dispTime[11:8];
         3'd6:    w_digit = w_dispTime[7:4];
         default: w_digit = w_dispTime[3:0];
      endcase
   end

   // Control FSM, prescaler and time count; clear outranks start_stop, which outranks lap.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= IDLE;
         r_time    <= 32'h0;
         r_pre     <= 16'd0;
         r_running <= 1'b0;
`ifdef LAP_EN
         r_snap    <= 32'h0;
         r_frozen  <= 1'b0;
`endif
      end else if (clear) begin
         r_state   <= IDLE;
         r_time    <= 32'h0;
         r_pre     <= 16'd0;
         r_running <= 1'b0;
`ifdef LAP_EN
         r_frozen  <= 1'b0;
`endif
      end else begin
         if (w_tick) begin
            r_pre  <= 16'd0;
            r_time <= incTime(r_time);
         end else if (w_counting) begin
            r_pre  <= r_pre + 16'd1;
         end
         if (start_stop) begin
            case (r_state)
               IDLE:  begin r_state <= RUN;   r_running <= 1'b1; end
               RUN:   begin r_state <= PAUSE; r_running <= 1'b0; end
               PAUSE: begin
                  r_state   <= RUN;
                  r_running <= 1'b1;
`ifdef LAP_EN
                  r_frozen  <= 1'b0;
`endif
               end
`ifdef LAP_EN
               LAP:   begin r_state <= PAUSE; r_running <= 1'b0; end
`endif
               default: r_state <= IDLE;
            endcase
`ifdef LAP_EN
         end else if (lap) begin
            case (r_state)
               RUN:   begin r_state <= LAP; r_snap <= r_time; r_frozen <= 1'b1; end
               LAP:   begin r_state <= RUN; r_frozen <= 1'b0; end
               PAUSE: r_frozen <= 1'b0;
               default: ;
            endcase
`endif
         end
      end
   end

   // Digit scan; the segment registers show the slot that was current before the edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_scanDiv <= 8'd0;
         r_slot    <= 3'd0;
         r_segCom  <= 8'hFF;
         r_segData <= 8'h00;
      end else begin
         r_segCom  <= ~(8'h80 >> r_slot);
         r_segData <= segOf(w_digit) | {7'd0, w_dp};
         if (r_scanDiv == SCAN_LAST) begin
            r_scanDiv <= 8'd0;
            r_slot    <= r_slot + 3'd1;
         end else begin
            r_scanDiv <= r_scanDiv + 8'd1;
         end
      end
   end

`ifndef LAP_EN
   assign w_unusedLap = lap;
`endif
   assign seg_data = r_segData;
   assign seg_com  = r_segCom;
   assign running  = r_running;
   assign time_bcd = r_time;

endmodule

// File: tb/tb_stopwatch_mux.sv
// Self-checking bench for stopwatch_mux: a centisecond-total model checked every cycle,
// plus hand-computed literal expectations for key points.

module tb_stopwatch_mux;

   localparam int CYC   = 10;
   localparam int SDIV  = 1;
   localparam int DAY24 = 24 * 360000;
   localparam int S_IDLE = 0, S_RUN = 1, S_PAUSE = 2, S_LAP = 3;

   logic        clk = 1'b0;
   logic        rst;
   logic        startStop, clear, lap;
   logic [7:0]  segData, segCom, segData100, segCom100;
   logic        running, running100;
   logic [31:0] timeBcd, timeBcd100;

   always #5 clk = ~clk;

   stopwatch_mux #(.CYC_PER_CS(CYC), .SCAN_DIV(SDIV), .HOUR_WRAP(24)) dut24 (
      .clk(clk), .rst(rst), .start_stop(startStop), .clear(clear), .lap(lap),
      .seg_data(segData), .seg_com(segCom), .running(running), .time_bcd(timeBcd));

   stopwatch_mux #(.CYC_PER_CS(CYC), .SCAN_DIV(SDIV), .HOUR_WRAP(100)) dut100 (
      .clk(clk), .rst(rst), .start_stop(startStop), .clear(clear), .lap(lap),
      .seg_data(segData100), .seg_com(segCom100), .running(running100), .time_bcd(timeBcd100));

   logic [7:0] segTab  [10] = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0, 8'hFE, 8'hF6};
   logic [7:0] comSeq  [8]  = '{8'h7F, 8'hBF, 8'hDF, 8'hEF, 8'hF7, 8'hFB, 8'hFD, 8'hFE};
   logic [7:0] dataSeq [8]  = '{8'h60, 8'hDB, 8'hF2, 8'h67, 8'hB6, 8'hBF, 8'hE0, 8'hFE};

   // Model state: whole time kept as total centiseconds
   int         mState, mPhase, mTotal, mSnap, mCycles, lapIgnored;
   bit         mFrozen, mValid;
   logic [7:0] expCom, expData;

   int          nChecks = 0, nFails = 0;
   int          litSeq = 0, litSeen = 0;
   int          litSel  [16];
   logic [31:0] litExp  [16];
   string       litName [16];

   function automatic logic [31:0] toBcd(input int total);
      int h, m, s, c;
      h = total / 360000;
      m = (total / 6000) % 60;
      s = (total / 100) % 60;
      c = total % 100;
      return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10),
              4'(s / 10), 4'(s % 10), 4'(c / 10), 4'(c % 10)};
   endfunction

   task automatic modelReset();
      mState = S_IDLE; mPhase = 0; mTotal = 0; mSnap = 0; mFrozen = 0; mCycles = 0;
      expCom = 8'hFF; expData = 8'h00;
   endtask

   task automatic modelStep(input bit ss, input bit clr, input bit lp);
      int k;
      logic [31:0] b;
      logic [3:0]  d;
      k = (mCycles / SDIV) % 8;
      b = toBcd(mFrozen ? mSnap : mTotal);
      d = b[(7 - k) * 4 +: 4];
      expCom  = ~(8'h80 >> k);
      expData = segTab[d] | (((k % 2) == 1 && k != 7) ? 8'h01 : 8'h00);
      mCycles++;
      if (clr) begin
         mState = S_IDLE; mTotal = 0; mPhase = 0; mFrozen = 0;
      end else begin
         int old;
         old = mTotal;
         if (mState == S_RUN || mState == S_LAP) begin
            if (mPhase == CYC - 1) begin
               mPhase = 0;
               mTotal = (mTotal + 1) % DAY24;
            end else begin
               mPhase++;
            end
         end
         if (ss) begin
            if (mState == S_IDLE || mState == S_PAUSE) begin
               mState = S_RUN; mFrozen = 0;
            end else begin
               mState = S_PAUSE;
            end
         end else if (lp) begin
`ifdef LAP_EN
            if (mState == S_RUN) begin
               mState = S_LAP; mSnap = old; mFrozen = 1;
            end else if (mState == S_LAP) begin
               mState = S_RUN; mFrozen = 0;
            end else if (mState == S_PAUSE) begin
               mFrozen = 0;
            end
`else
            lapIgnored++;
`endif
         end
      end
   endtask

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      nChecks++;
      if (act !== exp) begin
         nFails++;
         $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Compare process: reset values while rst is high, otherwise the model, plus pending literals
   always @(negedge clk) begin
      if (rst) begin
         checkOutput("rstTime", timeBcd, 32'h0);
         checkOutput("rstRunning", {31'd0, running}, 32'd0);
         checkOutput("rstCom", {24'd0, segCom}, 32'hFF);
         checkOutput("rstData", {24'd0, segData}, 32'h00);
      end else if (mValid) begin
         checkOutput("modelTime", timeBcd, toBcd(mTotal));
         checkOutput("modelRunning", {31'd0, running},
                     (mState == S_RUN || mState == S_LAP) ? 32'd1 : 32'd0);
         checkOutput("modelCom", {24'd0, segCom}, {24'd0, expCom});
         checkOutput("modelData", {24'd0, segData}, {24'd0, expData});
      end
      while (litSeen < litSeq) begin
         case (litSel[litSeen % 16])
            0:       checkOutput(litName[litSeen % 16], timeBcd, litExp[litSeen % 16]);
            1:       checkOutput(litName[litSeen % 16], {31'd0, running}, litExp[litSeen % 16]);
            2:       checkOutput(litName[litSeen % 16], timeBcd100, litExp[litSeen % 16]);
            3:       checkOutput(litName[litSeen % 16], {24'd0, segCom}, litExp[litSeen % 16]);
            default: checkOutput(litName[litSeen % 16], {24'd0, segData}, litExp[litSeen % 16]);
         endcase
         litSeen++;
      end
   end

   task automatic expectLit(input int sel, input logic [31:0] exp, input string name);
      litSel[litSeq % 16]  = sel;
      litExp[litSeq % 16]  = exp;
      litName[litSeq % 16] = name;
      litSeq++;
   endtask

   task automatic applyStimulus(input bit ss, input bit clr, input bit lp);
      startStop = ss; clear = clr; lap = lp;
      @(posedge clk);
      if (!rst) modelStep(ss, clr, lp);
      #1;
      startStop = 1'b0; clear = 1'b0; lap = 1'b0;
   endtask

   initial begin
      startStop = 1'b0; clear = 1'b0; lap = 1'b0; lapIgnored = 0;
      mValid = 0;
      rst = 1'b1;
      modelReset();
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      mValid = 1;

      // Scan sequence with 12:34:56.78 on the display
      mTotal = 12 * 360000 + 34 * 6000 + 56 * 100 + 78;
      force dut24.r_time = 32'h12345678;
      #1 release dut24.r_time;
      for (int i = 0; i < 8; i++) begin
         applyStimulus(0, 0, 0);
         expectLit(3, {24'd0, comSeq[i]}, "scanCom");
         expectLit(4, {24'd0, dataSeq[i]}, "scanData");
      end

      // First tick lands exactly CYC cycles after the start edge
      applyStimulus(0, 1, 0);
      expectLit(0, 32'h0, "clearTime");
      applyStimulus(1, 0, 0);
      repeat (CYC - 1) applyStimulus(0, 0, 0);
      expectLit(0, 32'h0, "preTick");
      expectLit(1, 32'd1, "runningAfterStart");
      applyStimulus(0, 0, 0);
      expectLit(0, 32'h00000001, "firstTick");

      // Pause with prescaler at 4, hold 20 cycles, resume and tick 5 cycles later
      while (mPhase != 4) applyStimulus(0, 0, 0);
      applyStimulus(1, 0, 0);
      repeat (20) applyStimulus(0, 0, 0);
      expectLit(0, 32'h00000001, "pauseHold");
      expectLit(1, 32'd0, "pausedNotRunning");
      applyStimulus(1, 0, 0);
      repeat (4) applyStimulus(0, 0, 0);
      expectLit(0, 32'h00000001, "resumeNoTickYet");
      applyStimulus(0, 0, 0);
      expectLit(0, 32'h00000002, "resumeTick");

      // Lap at 00:00:01.23, run on, then unfreeze
      applyStimulus(0, 1, 0);
      mTotal = 123;
      force dut24.r_time = 32'h00000123;
      #1 release dut24.r_time;
      applyStimulus(1, 0, 0);
      applyStimulus(0, 0, 1);
      repeat (30) applyStimulus(0, 0, 0);
      expectLit(0, 32'h00000126, "lapLiveAdvances");
      expectLit(1, 32'd1, "lapRunning");
`ifdef LAP_EN
      while (((mCycles / SDIV) % 8) != 7) applyStimulus(0, 0, 0);
      applyStimulus(0, 0, 0);
      expectLit(4, 32'hF2, "frozenCsOne");
`endif
      applyStimulus(0, 0, 1);
      repeat (10) applyStimulus(0, 0, 0);

      // clear, start_stop and lap together: clear wins
      applyStimulus(0, 0, 1);
      applyStimulus(1, 1, 1);
      expectLit(0, 32'h0, "clearWinsTime");
      expectLit(1, 32'd0, "clearWinsRunning");
      repeat (10) applyStimulus(0, 0, 0);

      // Hour wrap for both moduli
      mTotal = 23 * 360000 + 59 * 6000 + 59 * 100 + 99;
      force dut24.r_time  = 32'h23595999;
      force dut100.r_time = 32'h99595999;
      #1;
      release dut24.r_time;
      release dut100.r_time;
      applyStimulus(1, 0, 0);
      repeat (CYC - 1) applyStimulus(0, 0, 0);
      expectLit(0, 32'h23595999, "wrap24Before");
      expectLit(2, 32'h99595999, "wrap100Before");
      applyStimulus(0, 0, 0);
      expectLit(0, 32'h0, "wrap24");
      expectLit(2, 32'h0, "wrap100");

      // Asynchronous reset in the middle of a count
      repeat (5) applyStimulus(0, 0, 0);
      #1 rst = 1'b1;
      modelReset();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      expectLit(0, 32'h0, "afterRstTime");
      expectLit(1, 32'd0, "afterRstRunning");
      repeat (12) applyStimulus(0, 0, 0);
      expectLit(0, 32'h0, "idleAfterRst");

      @(negedge clk);
      #1;
      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule

// File: doc/stopwatch_mux.md
STOPWATCH_MUX -- requirements
Module: stopwatch_mux

Interface
REQ-001 The block SHALL have parameter CYC_PER_CS, default 10, meaning clk cycles per 1/100 s tick (legal range 2..65535).
REQ-002 The block SHALL have parameter SCAN_DIV, default 1, meaning clk cycles per display digit slot (legal range 1..255).
REQ-003 The block SHALL have parameter HOUR_WRAP, default 24, meaning the hours modulus (legal values 24 or 100).
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; the block uses one clock.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-006 The block SHALL have port start_stop, input, 1 bit: a one-cycle pulse that toggles run/pause.
REQ-007 The block SHALL have port clear, input, 1 bit: a one-cycle pulse that zeroes the time and returns the block to IDLE.
REQ-008 The block SHALL have port lap, input, 1 bit: a one-cycle pulse that freezes or unfreezes the display.
REQ-009 The block SHALL have port seg_data, output, 8 bits: segments {a,b,c,d,e,f,g,dp} on bit7..bit0, active-high.
REQ-010 The block SHALL have port seg_com, output, 8 bits: one-hot-low digit select, where bit7 is the leftmost digit.
REQ-011 The block SHALL have port running, output, 1 bit: high when the FSM is in state RUN or LAP.
REQ-012 The block SHALL have port time_bcd, output, 32 bits: the live count in BCD, {h_ten,h_one,m_ten,m_one,s_ten,s_one,cs_ten,cs_one}.

Function
REQ-013 The FSM SHALL have states IDLE, RUN, PAUSE, and LAP.
REQ-014 FSM transitions SHALL be as follows: IDLE goes to RUN on start_stop; RUN goes to PAUSE on start_stop; PAUSE goes to RUN on start_stop; RUN goes to LAP on lap; LAP goes to RUN on lap; LAP goes to PAUSE on start_stop, with the display remaining frozen.
REQ-015 A clear pulse in any state SHALL zero all digits, zero the prescaler, and move the FSM to IDLE on the next edge.
REQ-016 Input priority on a single cycle SHALL be clear, then start_stop, then lap; lower-priority pulses in that cycle SHALL be ignored.
REQ-017 A lap pulse in IDLE or PAUSE SHALL be ignored, except that a lap pulse in PAUSE while the display is frozen SHALL unfreeze it.
REQ-018 The prescaler SHALL count 0..CYC_PER_CS-1 only in RUN or LAP, SHALL hold its value in PAUSE, and SHALL issue a cs tick on its terminal count.
REQ-019 The first cs tick after IDLE→RUN SHALL occur exactly CYC_PER_CS cycles after the start_stop edge.
REQ-020 Digit carries SHALL ripple in the tick cycle: cs 00..99; s 00..59; m 00..59; h 00..HOUR_WRAP-1.
REQ-021 When HOUR_WRAP is 24, the count SHALL wrap from 23:59:59.99 to 00:00:00.00 on the next tick.
REQ-022 When HOUR_WRAP is 100, the count SHALL wrap from 99:59:59.99 to 00:00:00.00 on the next tick.
REQ-023 All digits SHALL be 4-bit BCD and SHALL never hold a value of 10..15.
REQ-024 On LAP entry, the live time SHALL be latched into a snapshot register.
REQ-025 While frozen, the display SHALL show the snapshot and time_bcd SHALL continue to show the live count.
REQ-026 The scan counter SHALL advance one slot every SCAN_DIV cycles, 0..7, and SHALL wrap to 0.
REQ-027 Slot k SHALL drive seg_com with bit (7-k) low and all other bits high.
REQ-028 seg_data and seg_com SHALL be registered and SHALL reflect the slot one cycle after the slot changes.
REQ-029 Digit sources per slot SHALL be: slot 0 h_ten, slot 1 h_one, slot 2 m_ten, slot 3 m_one, slot 4 s_ten, slot 5 s_one, slot 6 cs_ten, slot 7 cs_one.
REQ-030 The segment map SHALL be 0=FC, 1=60, 2=DA, 3=F2, 4=66, 5=B6, 6=BE, 7=E0, 8=FE, 9=F6 (hex, dp=0).
REQ-031 The dp bit SHALL be set on slots 1, 3, and 5 as separators.

Reset
REQ-032 While rst is high, the FSM SHALL be IDLE and all digits, the snapshot, the prescaler, and the scan counter SHALL be 0, asynchronously.
REQ-033 While rst is high, seg_com SHALL be FF, seg_data SHALL be 00, running SHALL be 0, and time_bcd SHALL be 00000000.
REQ-034 On rst deassertion, the first scan slot SHALL be 0; assertion of rst mid-count SHALL abort the count with no tick.

Configuration
REQ-035 When LAP_EN is defined, the lap input, the LAP state, and the snapshot register SHALL be implemented as specified above.
REQ-036 When LAP_EN is undefined, the lap input SHALL be ignored, the LAP state and snapshot SHALL be absent, and the display SHALL always show the live count.

Verification
REQ-037 The bench SHALL cover: rst, then start_stop with CYC_PER_CS=10 → time_bcd = 00000001 exactly 10 cycles later, and running=1.
REQ-038 The bench SHALL cover: preload 23595999, then one tick → time_bcd = 00000000 (HOUR_WRAP=24); with HOUR_WRAP=100, preload 99595999 → 00000000.
REQ-039 The bench SHALL cover: RUN, then start_stop at prescaler=4 → held 20 cycles; start_stop again → next tick after 5 cycles.
REQ-040 The bench SHALL cover: clear, start_stop, and lap in the same cycle during RUN → IDLE, time_bcd = 0, display not frozen.
REQ-041 The bench SHALL cover: with LAP_EN defined, lap at 00:00:01.23 → display digits stay 00000123 while time_bcd advances; lap again → live digits.
REQ-042 The bench SHALL cover: scan with SCAN_DIV=1, time 12345678 → seg_com sequence 7F, BF, DF, EF, F7, FB, FD, FE with seg_data 60, DB, F2, 67, B6, BF, E0, FE.
